// File: rtl/addf_pipe_pkg.sv
// Shared types and helpers for the carry-pipelined adder/subtractor.
// The operation encoding and the stage-0 carry selection live here.
package addf_pipe_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ADDC = 2'b01,
        OP_SUB  = 2'b10,
        OP_SUBB = 2'b11
    } op_e;

    // Subtraction is A + ~B + c0, so the carry-in doubles as an inverted borrow.
    function automatic logic cin_of(op_e op, logic ci);
        case (op)
            OP_ADD:  return 1'b0;
            OP_ADDC: return ci;
            OP_SUB:  return 1'b1;
            default: return ~ci;
        endcase
    endfunction

    function automatic logic is_sub(op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/addf_pipe_if.sv
// Operand/result stream bundle for addf_pipe.
// The slave modport is the adder side; the master modport is the producer/consumer side.
interface addf_pipe_if #(parameter int WIDTH = 16);
    import addf_pipe_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    op_e              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output in_valid, a, b, ci, op, out_ready,
        input  in_ready, out_valid, s, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, op, out_ready,
        output in_ready, out_valid, s, co, ovf
    );

endinterface

// File: rtl/addf_pipe_seg.sv
// Combinational SEG-bit ripple of full-adder bits.
// Also reports the carry into the segment MSB so the top segment can form signed overflow.
module addf_pipe_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_ci,
    output logic [SEG-1:0] o_sum,
    output logic           o_co,
    output logic           o_cmsb
);

    always_comb begin
        logic w_c;
        w_c    = i_ci;
        o_sum  = '0;
        o_cmsb = i_ci;
        for (int i = 0; i < SEG; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
            o_cmsb   = w_c;
            w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_co = w_c;
    end

endmodule

// File: rtl/addf_pipe.sv
// Carry-pipelined WIDTH-bit add/sub: STAGES ripple segments with registered carries,
// skewed operands and deskewed sums, under one global stall enable.
module addf_pipe
    import addf_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    addf_pipe_if.slave  io
);

    localparam int SEG = WIDTH / STAGES;

    logic                           w_en;
    logic [STAGES-1:0]              r_vld_pipe;
    logic [STAGES-1:0][WIDTH-1:0]   r_a;
    logic [STAGES-1:0][WIDTH-1:0]   r_bx;
    logic [STAGES-1:0][WIDTH-1:0]   r_s;
    logic [STAGES-1:0]              r_c;
    logic                           r_ovf;

    logic [STAGES-1:0][WIDTH-1:0]   w_ain;
    logic [STAGES-1:0][WIDTH-1:0]   w_bin;
    logic [STAGES-1:0][WIDTH-1:0]   w_sin;
    logic [STAGES-1:0][WIDTH-1:0]   w_snext;
    logic [STAGES-1:0][SEG-1:0]     w_sum;
    logic [STAGES-1:0]              w_cin;
    logic [STAGES-1:0]              w_vin;
    logic [STAGES-1:0]              w_co;
    logic [STAGES-1:0]              w_cmsb;

    assign w_en        = !r_vld_pipe[STAGES-1] || io.out_ready;
    assign io.in_ready = w_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        if (k == 0) begin : g_head
            assign w_ain[0] = io.a;
            assign w_bin[0] = is_sub(io.op) ? ~io.b : io.b;
            assign w_cin[0] = cin_of(io.op, io.ci);
            assign w_sin[0] = '0;
            assign w_vin[0] = io.in_valid;
        end else begin : g_body
            assign w_ain[k] = r_a[k-1];
            assign w_bin[k] = r_bx[k-1];
            assign w_cin[k] = r_c[k-1];
            assign w_sin[k] = r_s[k-1];
            assign w_vin[k] = r_vld_pipe[k-1];
        end

        addf_pipe_seg #(.SEG(SEG)) u_seg (
            .i_a    (w_ain[k][k*SEG +: SEG]),
            .i_b    (w_bin[k][k*SEG +: SEG]),
            .i_ci   (w_cin[k]),
            .o_sum  (w_sum[k]),
            .o_co   (w_co[k]),
            .o_cmsb (w_cmsb[k])
        );
    end

    always_comb begin
        w_snext = w_sin;
        for (int k = 0; k < STAGES; k++) begin
            w_snext[k][k*SEG +: SEG] = w_sum[k];
        end
    end

    // Data loads only behind a valid slot, so bubble operands never reach the outputs
    // and S/CO/OVF keep the last result while OUT_VALID is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
            r_a        <= '0;
            r_bx       <= '0;
            r_s        <= '0;
            r_c        <= '0;
            r_ovf      <= 1'b0;
        end else if (w_en) begin
            r_vld_pipe <= w_vin;
            for (int k = 0; k < STAGES; k++) begin
                if (w_vin[k]) begin
                    r_a[k]  <= w_ain[k];
                    r_bx[k] <= w_bin[k];
                    r_s[k]  <= w_snext[k];
                    r_c[k]  <= w_co[k];
                end
            end
            if (w_vin[STAGES-1]) r_ovf <= w_co[STAGES-1] ^ w_cmsb[STAGES-1];
        end
    end

    assign io.out_valid = r_vld_pipe[STAGES-1];
    assign io.s         = r_s[STAGES-1];
    assign io.co        = r_c[STAGES-1];
    assign io.ovf       = r_ovf;

    // Already-summed operand bits and inner MSB carries are dead past their stage.
    logic w_unused;
    assign w_unused = ^{r_a[STAGES-1], r_bx[STAGES-1], w_ain, w_bin, w_cmsb};

endmodule
